// File: rtl/databus_arbiter.sv
// Round-robin arbiter sharing one databus master port among N_REQ requesters.
// Grants are held for a whole burst; one idle cycle separates consecutive bursts.
module databus_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = 64,
    parameter int LEN_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             s_valid,
    output logic [N_REQ-1:0]             s_ready,
    input  logic [N_REQ*AXI_ADDR_W-1:0]  s_addr,
    input  logic [N_REQ*DATA_W-1:0]      s_wdata,
    input  logic [N_REQ*DATA_W/8-1:0]    s_wstrb,
    input  logic [N_REQ*LEN_W-1:0]       s_len,
    output logic [N_REQ*DATA_W-1:0]      s_rdata,
    output logic [N_REQ-1:0]             s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [AXI_ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W/8-1:0]          m_wstrb,
    output logic [LEN_W-1:0]             m_len,
    input  logic [DATA_W-1:0]            m_rdata,
    input  logic                         m_last,
    output logic                         busy,
    output logic [1:0]                   grant_id,
    output logic [15:0]                  burst_cnt
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] cnt_q, cnt_d;
    logic        found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        case (state_q)
            IDLE: begin
                // Rotating search: indices at/above ptr first, then wrap to those below.
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (!found && s_valid[i] && (2'(i) >= ptr_q)) begin
                        found   = 1'b1;
                        grant_d = 2'(i);
                    end
                end
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (!found && s_valid[i] && (2'(i) < ptr_q)) begin
                        found   = 1'b1;
                        grant_d = 2'(i);
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (m_valid && m_ready && m_last) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == 2'(N_REQ - 1)) ? '0 : grant_q + 2'd1;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        m_len   = '0;
        s_ready = '0;
        s_last  = '0;
        s_rdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if ((state_q == BUSY) && (grant_q == 2'(i))) begin
                m_valid                          = s_valid[i];
                m_addr                           = s_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
                m_wdata                          = s_wdata[i*DATA_W +: DATA_W];
                m_wstrb                          = s_wstrb[i*STRB_W +: STRB_W];
                m_len                            = s_len[i*LEN_W +: LEN_W];
                s_ready[i]                       = m_ready;
                s_last[i]                        = m_last;
                s_rdata[i*DATA_W +: DATA_W]      = m_rdata;
            end
        end
    end

    assign busy      = (state_q == BUSY);
    assign grant_id  = (state_q == BUSY) ? grant_q : '0;
    assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_databus_arbiter.sv
// Directed bench for databus_arbiter: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares every transfer.
module tb_databus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   s_valid;
    logic [1:0]   s_ready;
    logic [127:0] s_addr;
    logic [63:0]  s_wdata;
    logic [7:0]   s_wstrb;
    logic [15:0]  s_len;
    logic [63:0]  s_rdata;
    logic [1:0]   s_last;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic [7:0]   m_len;
    logic [31:0]  m_rdata;
    logic         m_last;
    logic         busy;
    logic [1:0]   grant_id;
    logic [15:0]  burst_cnt;

    databus_arbiter #(
        .N_REQ(2), .DATA_W(32), .AXI_ADDR_W(64), .LEN_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_len(s_len), .s_rdata(s_rdata), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_len(m_len), .m_rdata(m_rdata), .m_last(m_last),
        .busy(busy), .grant_id(grant_id), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] addr_v[2];
    logic [3:0]  strb_v[2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_beat actual=grant%0d expected=no_transfer", grant_id);
            end else begin
                exp_t        e;
                logic [1:0]  one;
                logic [63:0] er;
                e   = sb.pop_front();
                one = '0;
                one[e.id] = 1'b1;
                er  = '0;
                er[e.id*32 +: 32] = e.rdata;
                chk("mon_grant_id", grant_id, 2'(e.id));
                chk("mon_m_addr", m_addr, e.addr);
                chk("mon_m_wdata", m_wdata, e.wdata);
                chk("mon_m_wstrb", m_wstrb, strb_v[e.id]);
                chk("mon_s_ready", s_ready, one);
                chk("mon_s_last", s_last, e.last ? one : 2'b00);
                chk("mon_s_rdata", s_rdata, er);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One BUSY cycle for requester id; expectation queued only if a transfer should occur.
    task automatic beat(input int id, input int b, input logic rdy, input logic lst);
        logic [31:0] wd;
        logic [31:0] rd;
        wd = 32'hA000_0000 | 32'(id << 16) | 32'(b);
        rd = 32'h5000_0000 | 32'(id << 16) | 32'(b);
        s_wdata[id*32 +: 32] = wd;
        m_rdata = rd;
        m_ready = rdy;
        m_last  = lst;
        if (rdy && s_valid[id]) sb.push_back('{id, addr_v[id], wd, rd, lst});
        @(negedge clk);
        chk("beat_s_ready_mirror", s_ready[id], rdy);
        chk("beat_m_valid_follow", m_valid, s_valid[id]);
        tick();
    endtask

    task automatic grant_check(input int exp_id);
        tick();
        chk("grant_busy", busy, 1'b1);
        chk("grant_id", grant_id, 2'(exp_id));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        addr_v[0] = 64'h0000_0001_0000_1000;
        addr_v[1] = 64'h0000_0002_0000_2000;
        strb_v[0] = 4'hF;
        strb_v[1] = 4'h0;
        rst     = 1'b0;
        s_valid = 2'b11;
        s_addr  = {addr_v[1], addr_v[0]};
        s_wdata = '0;
        s_wstrb = {strb_v[1], strb_v[0]};
        s_len   = {8'd1, 8'd3};
        m_ready = 1'b1;
        m_last  = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();

        // Reset holds everything idle even with requests and ready/last present.
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_ready", s_ready, 2'b00);
        chk("rst_s_last", s_last, 2'b00);
        chk("rst_burst_cnt", burst_cnt, 16'd0);

        s_valid = 2'b00;
        m_ready = 1'b0;
        m_last  = 1'b0;
        rst     = 1'b1;
        tick();

        // Single requester, 4-beat burst.
        s_valid = 2'b01;
        @(negedge clk);
        chk("idle_m_valid_no_comb", m_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        grant_check(0);
        chk("single_m_len", m_len, 8'd3);
        for (int b = 0; b < 4; b++) beat(0, b, 1'b1, b == 3);
        s_valid = 2'b00;
        chk("single_end_busy", busy, 1'b0);
        chk("single_burst_cnt", burst_cnt, 16'd1);

        // ptr advanced to 1: requester 1 wins with both requesting.
        s_valid = 2'b11;
        grant_check(1);
        beat(1, 0, 1'b1, 1'b1);
        s_valid = 2'b00;
        chk("ptr1_burst_cnt", burst_cnt, 16'd2);

        // Contention from reset: grants 0,1,0 with one idle cycle between bursts.
        do_reset();
        s_valid = 2'b11;
        grant_check(0);
        beat(0, 0, 1'b1, 1'b0);
        beat(0, 1, 1'b1, 1'b1);
        chk("cont_idle_gap_busy", busy, 1'b0);
        @(negedge clk);
        chk("cont_idle_gap_m_valid", m_valid, 1'b0);
        tick();
        chk("cont_second_busy", busy, 1'b1);
        chk("cont_second_grant", grant_id, 2'd1);
        chk("cont_m_valid_2_after_last", m_valid, 1'b1);
        beat(1, 0, 1'b1, 1'b1);
        chk("cont_idle_gap2_busy", busy, 1'b0);
        grant_check(0);
        beat(0, 0, 1'b1, 1'b1);
        s_valid = 2'b00;
        chk("cont_burst_cnt", burst_cnt, 16'd3);

        // Backpressure: m_ready 1,0,1,0 over a 2-beat burst.
        s_valid = 2'b01;
        grant_check(0);
        beat(0, 0, 1'b1, 1'b0);
        beat(0, 1, 1'b0, 1'b0);
        chk("bp_still_busy", busy, 1'b1);
        beat(0, 1, 1'b1, 1'b1);
        s_valid = 2'b00;
        m_ready = 1'b0;
        chk("bp_done_busy", busy, 1'b0);
        tick();
        chk("bp_burst_cnt", burst_cnt, 16'd4);

        // Spurious last: without ready, then without valid, are both ignored.
        s_valid = 2'b01;
        grant_check(0);
        beat(0, 0, 1'b0, 1'b1);
        chk("spur_noready_busy", busy, 1'b1);
        s_valid = 2'b00;
        beat(0, 0, 1'b1, 1'b1);
        chk("spur_novalid_busy", busy, 1'b1);
        chk("spur_novalid_grant", grant_id, 2'd0);
        chk("spur_novalid_cnt", burst_cnt, 16'd4);
        s_valid = 2'b01;
        beat(0, 0, 1'b1, 1'b1);
        s_valid = 2'b00;
        chk("spur_end_busy", busy, 1'b0);
        chk("spur_burst_cnt", burst_cnt, 16'd5);

        // Reset mid-burst (ptr is 1 beforehand); abort is immediate, ptr restarts at 0.
        s_valid = 2'b01;
        grant_check(0);
        beat(0, 0, 1'b1, 1'b0);
        m_ready = 1'b1;
        m_last  = 1'b0;
        rst     = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_s_ready", s_ready, 2'b00);
        chk("mid_rst_grant_id", grant_id, 2'd0);
        chk("mid_rst_burst_cnt", burst_cnt, 16'd0);
        tick();
        rst     = 1'b1;
        s_valid = 2'b11;
        grant_check(0);
        beat(0, 0, 1'b1, 1'b1);
        s_valid = 2'b00;
        chk("post_rst_burst_cnt", burst_cnt, 16'd1);

        // Counter wrap: 65536 single-beat bursts.
        do_reset();
        s_wdata[31:0] = 32'hC0DE_0000;
        m_rdata = 32'h1234_5678;
        m_ready = 1'b1;
        m_last  = 1'b1;
        s_valid = 2'b01;
        for (int i = 0; i < 65536; i++) begin
            tick();
            sb.push_back('{0, addr_v[0], 32'hC0DE_0000, 32'h1234_5678, 1'b1});
            tick();
            if (i == 65534) chk("wrap_cnt_max", burst_cnt, 16'hFFFF);
        end
        s_valid = 2'b00;
        chk("wrap_cnt_zero", burst_cnt, 16'd0);

        repeat (2) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/databus_arbiter.md
DATABUS_ARBITER -- requirements
Module: databus_arbiter

Interface
REQ-001 Parameters SHALL be:
- N_REQ, default 2, number of requesters (2..4).
- DATA_W, default 32, data width.
- AXI_ADDR_W, default 64, address width.
- LEN_W, default 8, burst length width.
REQ-002 Requester-side vector ports SHALL pack requester i at bits [i*W +: W], where W is that port's per-requester width.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  reset
- s_valid  in  N_REQ  per-requester request/beat valid
- s_ready  out  N_REQ  per-requester beat accepted
- s_addr  in  N_REQ*AXI_ADDR_W  burst start address
- s_wdata  in  N_REQ*DATA_W  write data
- s_wstrb  in  N_REQ*DATA_W/8  write strobes (0 = read)
- s_len  in  N_REQ*LEN_W  burst length minus one
- s_rdata  out  N_REQ*DATA_W  read data
- s_last  out  N_REQ  last beat of burst
- m_valid  out  1  shared databus valid
- m_ready  in  1  shared databus ready
- m_addr  out  AXI_ADDR_W  shared address
- m_wdata  out  DATA_W  shared write data
- m_wstrb  out  DATA_W/8  shared strobes
- m_len  out  LEN_W  shared length
- m_rdata  in  DATA_W  shared read data
- m_last  in  1  shared last beat
- busy  out  1  a grant is held
- grant_id  out  2  index of granted requester, valid while busy
- burst_cnt  out  16  completed bursts since reset, wraps
REQ-004 The block SHALL use one clock, clk, rising edge; reset rst SHALL be asynchronous and active-low (asserted when rst=0).

Function
REQ-005 The block SHALL share one databus master port among N_REQ requesters using round-robin arbitration at burst granularity.
REQ-006 FSM states SHALL be IDLE and BUSY, plus a registered priority pointer ptr (0..N_REQ-1).
REQ-007 In IDLE with any s_valid bit high, the block SHALL register grant = first requester with s_valid=1, searching ptr, ptr+1, ... modulo N_REQ; the next state SHALL be BUSY.
REQ-008 In IDLE, m_valid SHALL be 0 and all s_ready SHALL be 0; no combinational path from s_valid to m_valid.
REQ-009 In BUSY with grant g, the m_* outputs SHALL be driven by the registered grant only:
- m_valid=s_valid[g]
- m_addr, m_wdata, m_wstrb, m_len = requester g's fields
- s_ready[g]=m_ready
- s_last[g]=m_last
- s_rdata[g]=m_rdata
REQ-010 Non-granted requesters SHALL see s_ready=0, s_last=0 and s_rdata=0.
REQ-011 A beat SHALL transfer when m_valid and m_ready are both high in the same cycle.
REQ-012 On a transfer with m_last=1, the block SHALL set ptr=(g+1) mod N_REQ, increment burst_cnt (modulo 2^16), and return to IDLE next cycle.
REQ-013 The grant SHALL be held for the whole burst even if s_valid[g] drops mid-burst; m_valid follows s_valid[g] while held.
REQ-014 Exactly one idle cycle SHALL separate consecutive bursts: a request present during a last-beat cycle is granted at the following IDLE edge and drives m_valid two cycles after the last beat.
REQ-015 m_last observed without a transfer (m_valid=0 or m_ready=0) SHALL be ignored.
REQ-016 A requester whose s_valid deasserts before being granted SHALL lose no state; arbitration uses only the current cycle's s_valid.
REQ-017 busy SHALL be 1 exactly in BUSY; grant_id SHALL equal g in BUSY and 0 in IDLE.
REQ-018 With N_REQ < 4, unused grant_id encodings SHALL never occur.

Reset
REQ-019 While rst=0, the block SHALL hold state=IDLE, ptr=0, grant=0, burst_cnt=0, busy=0, grant_id=0, m_valid=0, all s_ready=0 and all s_last=0, asynchronously and independent of clk.
REQ-020 Reset asserted mid-burst SHALL abort the burst immediately (m_valid=0 within the reset assertion); after release the block SHALL start from IDLE with ptr=0.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Single requester: s_valid[0]=1, s_len=3, m_ready=1, m_last on beat 4 -> busy rises 1 cycle after s_valid; 4 beats reach s_ready[0]; s_last[0] on beat 4; burst_cnt=1; ptr=1.
- Contention: s_valid=2'b11 from reset -> requester 0 granted first, then requester 1 after one idle cycle, then requester 0 again; grant_id sequence 0,1,0.
- Backpressure: m_ready toggles 1,0,1,0 during a 2-beat burst -> exactly 2 transfers; s_ready[g] mirrors m_ready; no extra burst_cnt increments.
- Spurious last: m_last=1 with m_ready=0 -> stays BUSY; the later m_last with m_ready=1 -> IDLE next cycle.
- Reset mid-burst: rst=0 on beat 2 of 4 -> m_valid=0 and busy=0 immediately; burst_cnt=0; first grant after release goes to requester 0.
- Counter wrap: 65536 single-beat bursts -> burst_cnt returns to 0.
